// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic read-modify-write of mscratch and the 64-bit cycle/instret counters.
// Define CSR_INSTRET_EN to include the instret counter (0xB02/0xB82/0xC02/0xC82).
module csr_file #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            csr_en_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_control_i,
  input  logic            csr_src_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic            instr_retired_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o
);

  localparam logic [1:0] CSR_PASS    = 2'd0;
  localparam logic [1:0] CSR_SET     = 2'd1;
  localparam logic [1:0] CSR_CLEAR   = 2'd2;
  localparam logic [1:0] CSR_NA      = 2'd3;
  localparam logic       CSR_SRC_REG = 1'b0;
  localparam logic       CSR_SRC_IMM = 1'b1;

  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [63:0]     cycle_q, cycle_d;
`ifdef CSR_INSTRET_EN
  logic [63:0]     instret_q, instret_d;
`else
  logic            unused_retired;
  assign unused_retired = instr_retired_i;
`endif

  logic [XLEN-1:0] operand, old_val, new_val;
  logic            write_intent, implemented, illegal_raw, do_write;

  always_comb begin
    operand = (csr_src_i == CSR_SRC_IMM) ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

    // SET/CLEAR with rs1 field 0 are pure reads, whatever the operand source.
    unique case (csr_control_i)
      CSR_PASS:            write_intent = 1'b1;
      CSR_SET, CSR_CLEAR:  write_intent = (rs1_idx_i != 5'd0);
      default:             write_intent = 1'b0;
    endcase

    implemented = 1'b1;
    old_val     = '0;
    case (csr_addr_i)
      12'h340:          old_val = mscratch_q;
      12'hB00, 12'hC00: old_val = cycle_q[31:0];
      12'hB80, 12'hC80: old_val = cycle_q[63:32];
`ifdef CSR_INSTRET_EN
      12'hB02, 12'hC02: old_val = instret_q[31:0];
      12'hB82, 12'hC82: old_val = instret_q[63:32];
`endif
      default:          implemented = 1'b0;
    endcase

    illegal_raw = !implemented || (write_intent && (csr_addr_i[11:10] == 2'b11));
    do_write    = csr_en_i && write_intent && !illegal_raw;

    unique case (csr_control_i)
      CSR_PASS:  new_val = operand;
      CSR_SET:   new_val = old_val | operand;
      CSR_CLEAR: new_val = old_val & ~operand;
      default:   new_val = old_val;
    endcase

    csr_illegal_o = reset_n_i && csr_en_i && illegal_raw;
    csr_rdata_o   = (reset_n_i && !illegal_raw) ? old_val : '0;
  end

  // A software write replaces the increment for that cycle in both halves.
  always_comb begin
    mscratch_d = mscratch_q;
    if (do_write && csr_addr_i == 12'h340) mscratch_d = new_val;

    cycle_d = cycle_q + 64'd1;
    if (do_write && csr_addr_i == 12'hB00) cycle_d = {cycle_q[63:32], new_val};
    if (do_write && csr_addr_i == 12'hB80) cycle_d = {new_val, cycle_q[31:0]};
`ifdef CSR_INSTRET_EN
    instret_d = instr_retired_i ? instret_q + 64'd1 : instret_q;
    if (do_write && csr_addr_i == 12'hB02) instret_d = {instret_q[63:32], new_val};
    if (do_write && csr_addr_i == 12'hB82) instret_d = {new_val, instret_q[31:0]};
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mscratch_q <= '0;
      cycle_q    <= '0;
`ifdef CSR_INSTRET_EN
      instret_q  <= '0;
`endif
    end else begin
      mscratch_q <= mscratch_d;
      cycle_q    <= cycle_d;
`ifdef CSR_INSTRET_EN
      instret_q  <= instret_d;
`endif
    end
  end

endmodule
